// File: rtl/lm32_tlb_assoc.sv
`default_nettype none
// ============================================================================
// Module  : lm32_tlb_assoc
// Brief   : N-way set-associative TLB with ASID/global tagging, permission
//           checks, round-robin replacement and a per-ASID flush walker.
// Revision: 1.0 - initial release
// ============================================================================
module lm32_tlb_assoc #(
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int PAGE_SIZE  = 4096,
    parameter int ASID_WIDTH = 8,
    parameter int MODE       = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable,
    input  logic                  stall_a,
    input  logic                  stall_f,
    input  logic                  stall_d,
    input  logic                  stall_x,
    input  logic [31:0]           vaddr_a,
    input  logic [31:0]           vaddr_f,
    input  logic                  store_f,
    input  logic [ASID_WIDTH-1:0] asid,
    input  logic [31:0]           tlbvaddr,
    input  logic [31:0]           tlbpaddr,
    input  logic [3:0]            tlbperm,
    input  logic                  update,
    input  logic                  invalidate,
    input  logic                  flush,
    input  logic                  flush_asid,
    output logic [31:0]           paddr_f,
    output logic                  hit_f,
    output logic                  miss_f,
    output logic                  fault_f,
    output logic                  miss_x,
    output logic                  fault_x,
    output logic                  stall_request
);

    localparam int c_off_w = $clog2(PAGE_SIZE);
    localparam int c_idx_w = $clog2(SETS);
    localparam int c_tag_w = 32 - c_off_w - c_idx_w;
    localparam int c_ppn_w = 32 - c_off_w;
    localparam int c_ptr_w = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WALK = 1'b1
    } state_t;

    // Entry storage; perm_q holds {X,W,R}, the G bit lives in global_q.
    logic [WAYS-1:0]       valid_q  [SETS];
    logic [WAYS-1:0]       valid_d  [SETS];
    logic [WAYS-1:0]       global_q [SETS];
    logic [ASID_WIDTH-1:0] asid_q   [SETS][WAYS];
    logic [c_tag_w-1:0]    tag_q    [SETS][WAYS];
    logic [c_ppn_w-1:0]    ppn_q    [SETS][WAYS];
    logic [2:0]            perm_q   [SETS][WAYS];
    logic [c_ptr_w-1:0]    ptr_q    [SETS];
    logic [c_ptr_w-1:0]    ptr_d    [SETS];

    logic [c_idx_w-1:0]    idx_f_q, idx_f_d;
    logic                  miss_d_q, miss_d_d, fault_d_q, fault_d_d;
    logic                  miss_x_q, miss_x_d, fault_x_q, fault_x_d;
    state_t                state_q, state_d;
    logic [c_idx_w-1:0]    cnt_q, cnt_d;
    logic [ASID_WIDTH-1:0] walk_asid_q, walk_asid_d;

    logic [c_tag_w-1:0]    w_tag_f;
    logic                  w_hit;
    logic [c_ppn_w-1:0]    w_ppn;
    logic [2:0]            w_perm;
    logic                  w_deny;

    logic [c_idx_w-1:0]    w_u_idx;
    logic [c_tag_w-1:0]    w_u_tag;
    logic                  w_u_hit;
    logic [c_ptr_w-1:0]    w_u_hit_way;
    logic                  w_u_free;
    logic [c_ptr_w-1:0]    w_u_free_way;
    logic [c_ptr_w-1:0]    w_u_way;
    logic                  w_u_bump;
    logic                  w_wr_en;
    logic                  w_unused;

    assign w_tag_f = vaddr_f[31 -: c_tag_w];
    assign w_u_idx = tlbvaddr[c_off_w +: c_idx_w];
    assign w_u_tag = tlbvaddr[31 -: c_tag_w];
    assign w_unused = ^{vaddr_a[c_off_w-1:0], vaddr_a[31:c_off_w+c_idx_w],
                        tlbvaddr[c_off_w-1:0], tlbpaddr[c_off_w-1:0]};

    // F-stage lookup in the set captured from the A-stage address.
    always_comb begin
        w_hit  = 1'b0;
        w_ppn  = '0;
        w_perm = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx_f_q][w] && (tag_q[idx_f_q][w] == w_tag_f) &&
                (global_q[idx_f_q][w] || (asid_q[idx_f_q][w] == asid))) begin
                w_hit  = 1'b1;
                w_ppn  = ppn_q[idx_f_q][w];
                w_perm = perm_q[idx_f_q][w];
            end
        end
        w_deny = (MODE == 0) ? !w_perm[2] : (store_f ? !w_perm[1] : !w_perm[0]);
    end

    always_comb begin
        if (!enable) begin
            paddr_f = vaddr_f;
            hit_f   = 1'b1;
            miss_f  = 1'b0;
            fault_f = 1'b0;
        end else begin
            paddr_f = w_hit ? {w_ppn, vaddr_f[c_off_w-1:0]} : 32'd0;
            hit_f   = w_hit;
            miss_f  = !w_hit && !stall_f;
            fault_f = w_hit && w_deny && !stall_f;
        end
    end

    always_comb begin
        idx_f_d   = stall_a ? idx_f_q : vaddr_a[c_off_w +: c_idx_w];
        miss_d_d  = stall_d ? miss_d_q : miss_f;
        fault_d_d = stall_d ? fault_d_q : fault_f;
        miss_x_d  = stall_x ? miss_x_q : miss_d_q;
        fault_x_d = stall_x ? fault_x_q : fault_d_q;
    end

    // Way selection for update/invalidate: exact VPN+ASID match ignores G.
    always_comb begin
        w_u_hit      = 1'b0;
        w_u_hit_way  = '0;
        w_u_free     = 1'b0;
        w_u_free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[w_u_idx][w] && (tag_q[w_u_idx][w] == w_u_tag) &&
                (asid_q[w_u_idx][w] == asid)) begin
                w_u_hit     = 1'b1;
                w_u_hit_way = c_ptr_w'(w);
            end
            if (!valid_q[w_u_idx][w]) begin
                w_u_free     = 1'b1;
                w_u_free_way = c_ptr_w'(w);
            end
        end
        w_u_bump = !w_u_hit && !w_u_free;
        w_u_way  = w_u_hit ? w_u_hit_way : (w_u_free ? w_u_free_way : ptr_q[w_u_idx]);
    end

    // Maintenance priority: flush > walk/flush_asid > update > invalidate.
    always_comb begin
        for (int s = 0; s < SETS; s++) begin
            valid_d[s] = valid_q[s];
            ptr_d[s]   = ptr_q[s];
        end
        state_d     = state_q;
        cnt_d       = cnt_q;
        walk_asid_d = walk_asid_q;
        w_wr_en     = 1'b0;
        if (flush) begin
            for (int s = 0; s < SETS; s++) begin
                valid_d[s] = '0;
            end
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (state_q == S_WALK) begin
            for (int w = 0; w < WAYS; w++) begin
                if (!global_q[cnt_q][w] && (asid_q[cnt_q][w] == walk_asid_q)) begin
                    valid_d[cnt_q][w] = 1'b0;
                end
            end
            if (cnt_q == c_idx_w'(SETS - 1)) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (flush_asid) begin
            walk_asid_d = asid;
            cnt_d       = '0;
            state_d     = S_WALK;
        end else if (update) begin
            w_wr_en                    = 1'b1;
            valid_d[w_u_idx][w_u_way] = 1'b1;
            if (w_u_bump) begin
                ptr_d[w_u_idx] = (ptr_q[w_u_idx] == c_ptr_w'(WAYS - 1)) ? '0
                                                                       : ptr_q[w_u_idx] + 1'b1;
            end
        end else if (invalidate && w_u_hit) begin
            valid_d[w_u_idx][w_u_hit_way] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            walk_asid_q <= '0;
            idx_f_q     <= '0;
            miss_d_q    <= 1'b0;
            fault_d_q   <= 1'b0;
            miss_x_q    <= 1'b0;
            fault_x_q   <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            walk_asid_q <= walk_asid_d;
            idx_f_q     <= idx_f_d;
            miss_d_q    <= miss_d_d;
            fault_d_q   <= fault_d_d;
            miss_x_q    <= miss_x_d;
            fault_x_q   <= fault_x_d;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= valid_d[s];
                ptr_q[s]   <= ptr_d[s];
            end
        end
    end

    // Payload fields are qualified by valid_q, so they need no reset.
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            global_q[w_u_idx][w_u_way] <= tlbperm[3];
            perm_q[w_u_idx][w_u_way]   <= tlbperm[2:0];
            asid_q[w_u_idx][w_u_way]   <= asid;
            tag_q[w_u_idx][w_u_way]    <= w_u_tag;
            ppn_q[w_u_idx][w_u_way]    <= tlbpaddr[31:c_off_w];
        end
    end

    assign miss_x        = miss_x_q;
    assign fault_x       = fault_x_q;
    assign stall_request = (state_q == S_WALK);

endmodule
`default_nettype wire
